// File: rtl/ram_arbiter.sv
// Single-port arbiter for the shared system RAM (loader / video DMA / CPU).
// Latency: grant in cycle N, RAM strobe in N+1, read data and rvalid in N+2.
// Backpressure: a requester holds req/addr/data until it sees its combinational ack.
//
// Ports:
//   clk, reset_n                    clock, synchronous active-low reset
//   dl_active                       download session flag (RUN <-> LOAD)
//   ld_req/ld_addr/ld_din/ld_ack    loader write port; ld_count = bytes written this session
//   dma_req/dma_addr/dma_ack        video DMA read port; dma_rvalid/dma_rdata return path
//   cpu_req/cpu_wr/cpu_addr/cpu_din CPU port; cpu_ack, cpu_rvalid/cpu_rdata return path
//   ram_ce/ram_wr/ram_addr/ram_din  registered RAM command; ram_dout valid cycle after ram_ce
module ram_arbiter #(
    parameter int DATA         = 8,
    parameter int ADDR         = 14,
    parameter int CPU_WAIT_MAX = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dl_active,
    input  logic              ld_req,
    input  logic [ADDR-1:0]   ld_addr,
    input  logic [DATA-1:0]   ld_din,
    output logic              ld_ack,
    output logic [ADDR:0]     ld_count,
    input  logic              dma_req,
    input  logic [ADDR-1:0]   dma_addr,
    output logic              dma_ack,
    output logic              dma_rvalid,
    output logic [DATA-1:0]   dma_rdata,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR-1:0]   cpu_addr,
    input  logic [DATA-1:0]   cpu_din,
    output logic              cpu_ack,
    output logic              cpu_rvalid,
    output logic [DATA-1:0]   cpu_rdata,
    output logic              ram_ce,
    output logic              ram_wr,
    output logic [ADDR-1:0]   ram_addr,
    output logic [DATA-1:0]   ram_din,
    input  logic [DATA-1:0]   ram_dout
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    // Owner of a read travelling through the two-stage return pipeline.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DMA  = 2'd1,
        TAG_CPU  = 2'd2
    } tag_t;

    localparam logic [3:0]  WAIT_MAX  = 4'(CPU_WAIT_MAX);
    localparam logic [3:0]  WAIT_ONE  = 4'd1;
    localparam logic [ADDR:0] COUNT_MAX = {1'b1, {ADDR{1'b0}}};
    localparam logic [ADDR:0] COUNT_ONE = {{ADDR{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [3:0]        cpu_wait_q, cpu_wait_d;
    logic [ADDR:0]     ld_count_q, ld_count_d;
    logic              ram_ce_q, ram_ce_d;
    logic              ram_wr_q, ram_wr_d;
    logic [ADDR-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA-1:0]   ram_din_q, ram_din_d;
    tag_t              tag1_q, tag1_d;
    tag_t              tag2_q, tag2_d;

    logic              ld_grant;
    logic              dma_grant;
    logic              cpu_grant;
    logic              cpu_first;

    // Grant decision. Held off while reset is asserted so nothing is
    // acknowledged that the reset edge would then throw away.
    always_comb begin
        ld_grant  = 1'b0;
        dma_grant = 1'b0;
        cpu_grant = 1'b0;
        cpu_first = 1'b0;
        if (reset_n) begin
            if (state_q == ST_LOAD) begin
                ld_grant = ld_req;
            end else begin
                // CPU jumps the queue once it has been starved long enough.
                cpu_first = cpu_req && (cpu_wait_q >= WAIT_MAX);
                dma_grant = dma_req && !cpu_first;
                cpu_grant = cpu_req && !dma_grant;
            end
        end
    end

    assign ld_ack  = ld_grant;
    assign dma_ack = dma_grant;
    assign cpu_ack = cpu_grant;

    // Next-state for session FSM, starvation counter and loader byte count.
    always_comb begin
        state_d    = dl_active ? ST_LOAD : ST_RUN;

        cpu_wait_d = cpu_wait_q;
        if (!cpu_req || cpu_grant) begin
            cpu_wait_d = 4'd0;
        end else if (dma_grant && (cpu_wait_q < WAIT_MAX)) begin
            cpu_wait_d = cpu_wait_q + WAIT_ONE;
        end

        ld_count_d = ld_count_q;
        if ((state_q == ST_RUN) && dl_active) begin
            // New session starts counting from zero on the entry edge.
            ld_count_d = '0;
        end else if (ld_grant && (ld_count_q != COUNT_MAX)) begin
            ld_count_d = ld_count_q + COUNT_ONE;
        end
    end

    // RAM command register and read-owner pipeline.
    always_comb begin
        ram_ce_d   = 1'b0;
        ram_wr_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        tag1_d     = TAG_NONE;
        if (ld_grant) begin
            ram_wr_d   = 1'b1;
            ram_addr_d = ld_addr;
            ram_din_d  = ld_din;
        end else if (dma_grant) begin
            ram_ce_d   = 1'b1;
            ram_addr_d = dma_addr;
            tag1_d     = TAG_DMA;
        end else if (cpu_grant) begin
            ram_ce_d   = !cpu_wr;
            ram_wr_d   = cpu_wr;
            ram_addr_d = cpu_addr;
            ram_din_d  = cpu_din;
            tag1_d     = cpu_wr ? TAG_NONE : TAG_CPU;
        end
        // Stage 2 lines up with ram_dout, one cycle after the strobe.
        tag2_d = tag1_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_RUN;
            cpu_wait_q <= 4'd0;
            ld_count_q <= '0;
            ram_ce_q   <= 1'b0;
            ram_wr_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            tag1_q     <= TAG_NONE;
            tag2_q     <= TAG_NONE;
        end else begin
            state_q    <= state_d;
            cpu_wait_q <= cpu_wait_d;
            ld_count_q <= ld_count_d;
            ram_ce_q   <= ram_ce_d;
            ram_wr_q   <= ram_wr_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            tag1_q     <= tag1_d;
            tag2_q     <= tag2_d;
        end
    end

    assign ld_count   = ld_count_q;
    assign ram_ce     = ram_ce_q;
    assign ram_wr     = ram_wr_q;
    assign ram_addr   = ram_addr_q;
    assign ram_din    = ram_din_q;

    assign dma_rvalid = (tag2_q == TAG_DMA);
    assign cpu_rvalid = (tag2_q == TAG_CPU);
    assign dma_rdata  = dma_rvalid ? ram_dout : '0;
    assign cpu_rdata  = cpu_rvalid ? ram_dout : '0;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Single-port access arbiter placed in front of one port of the shared 8-bit system RAM. It multiplexes three requesters onto that port: the cartridge/ROM download loader, the video DMA fetch engine, and the CPU bus. It grants at most one access per clock and returns read data with a fixed latency. It also blocks CPU and DMA traffic while a download session is active, and counts the bytes written by the loader.

## Interface
- DATA, 8, RAM data width
- ADDR, 14, RAM address width
- CPU_WAIT_MAX, 3, consecutive DMA-blocked cycles after which a CPU request beats DMA (1..15)
- clk  in  1  system clock
- reset_n  in  1  synchronous reset, active-low
- dl_active  in  1  loader download session active
- ld_req  in  1  loader write request
- ld_addr  in  ADDR  loader write address
- ld_din  in  DATA  loader write data
- ld_ack  out  1  loader request accepted this cycle
- ld_count  out  ADDR+1  bytes written in current/last session
- dma_req  in  1  video DMA read request
- dma_addr  in  ADDR  DMA read address
- dma_ack  out  1  DMA request accepted this cycle
- dma_rvalid  out  1  dma_rdata valid
- dma_rdata  out  DATA  DMA read data
- cpu_req  in  1  CPU request
- cpu_wr  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR  CPU address
- cpu_din  in  DATA  CPU write data
- cpu_ack  out  1  CPU request accepted this cycle
- cpu_rvalid  out  1  cpu_rdata valid
- cpu_rdata  out  DATA  CPU read data
- ram_ce  out  1  RAM read enable (registered)
- ram_wr  out  1  RAM write enable (registered)
- ram_addr  out  ADDR  RAM address (registered)
- ram_din  out  DATA  RAM write data (registered)
- ram_dout  in  DATA  RAM read data; valid the cycle after ram_ce

## Operation
- FSM has two states, RUN and LOAD. Reset enters RUN.
- RUN -> LOAD when dl_active=1 is sampled. On that edge, ld_count is cleared to 0.
- LOAD -> RUN when dl_active=0 is sampled. ld_count holds its value.
- In LOAD, only the loader is granted: ld_ack = ld_req. CPU and DMA get no ack; their requests stay pending.
- In RUN, ld_req is ignored. Grant priority is DMA over CPU, except when cpu_wait reaches CPU_WAIT_MAX; then the CPU wins.
- The *_ack signals are combinational from the current req inputs, FSM state and cpu_wait. A requester must hold req, addr and data stable until it sees ack. It may present a new request in the cycle after ack.
- cpu_wait counter (4 bits):
  - increments when cpu_req=1 and the DMA is granted;
  - clears on a CPU grant or when cpu_req=0;
  - saturates at CPU_WAIT_MAX.
- On a grant, the next edge registers the access onto the RAM port:
  - read: ram_ce=1, ram_wr=0;
  - write: ram_wr=1, ram_ce=0;
  - ram_addr and ram_din are loaded from the granted requester.
- With no grant, ram_ce=ram_wr=0 and ram_addr/ram_din hold their values.
- Each read carries an owner tag through a 2-stage pipeline. When the data returns, the matching rvalid is high for exactly one cycle and rdata = ram_dout. When the owner's rvalid is low, its rdata is 0.
- Each loader write grant increments ld_count, saturating at 2**ADDR.
- Reads already in flight complete normally across a RUN/LOAD transition.
- reset_n=0 on any edge:
  - FSM returns to RUN; cpu_wait, ld_count and the tag pipeline clear;
  - all outputs go to 0, including ram_addr and ram_din;
  - in-flight reads are discarded and no rvalid follows.

## Timing
- Cycle N: req high, ack high in the same cycle.
- Cycle N+1: ram_ce or ram_wr = 1 with the requester's address.
- Cycle N+2: rvalid = 1 with rdata valid. Read latency is 2 cycles from ack.
- A write is visible to a read granted in cycle N+1 or later.
- Throughput is one access per cycle. Back-to-back grants to the same or different requesters are allowed.
- The FSM change takes effect in the cycle after dl_active is sampled. In the sampling cycle, grants still follow the old state.
- If CPU and DMA both request while cpu_wait < CPU_WAIT_MAX, the DMA is granted. With the default CPU_WAIT_MAX=3, continuous DMA plus CPU requests give at most 3 DMA grants, then 1 CPU grant, repeating.

## Test plan
- CPU write 0x5A to 0x0123, then a CPU read of 0x0123 in the next cycle -> cpu_ack on both requests; cpu_rvalid 2 cycles after the read ack with cpu_rdata=0x5A; dma_rvalid stays 0.
- DMA and CPU reads held high continuously (CPU_WAIT_MAX=3) -> ack sequence DMA, DMA, DMA, CPU, repeating; each rvalid routed to the correct owner with the correct data.
- dl_active=1, then 300 ld_req writes while cpu_req and dma_req are held -> only ld_ack pulses and ld_count=300. After dl_active=0, CPU and DMA are acked on the next cycle, and ld_count stays at 300.
- Loader writes 2**ADDR+5 bytes -> ld_count saturates at 0x4000 (for ADDR=14).
- DMA read acked, then reset_n=0 asserted in cycle N+1 -> no dma_rvalid follows; all outputs are 0 in the cycle after reset; FSM is in RUN.
- dl_active rises in the cycle a CPU read is acked -> the CPU read completes with cpu_rvalid at N+2; no further CPU acks until dl_active falls.
